// File: rtl/flappy_pkg.sv
// Purpose: shared types, bounds and the BCD increment helper for the game sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_DYING     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam logic [15:0] BCD_MAX          = 16'h9999;
  localparam logic [9:0]  CEIL_Y_DEF       = 10'd35;
  localparam logic [9:0]  FLOOR_Y_DEF      = 10'd500;
  localparam logic [7:0]  DEATH_FRAMES_DEF = 8'd60;

  // Adds one to a 4-digit BCD value; a digit at 9 wraps to 0 and carries on.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Purpose: groups the datapath-facing signals of the game sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/pulse qualified, no handshake.
// Ports: master = pixel/physics datapath side (drives buttons, frame timing,
//        pixel flags, bird_y); slave = game_state_ctrl (drives enables, state, scores).
interface game_state_ctrl_if;
  logic        start_button;
  logic        flap_button;
  logic        frame_tick;
  logic        bright;
  logic        bird_px;
  logic        pipe_px;
  logic        pipe_passed;
  logic [9:0]  bird_y;
  logic        pipe_run_en;
  logic        physics_en;
  logic        physics_clr;
  logic        flap_pulse;
  logic [1:0]  state;
  logic [15:0] score;
  logic [15:0] high_score;

  modport master (
    output start_button, flap_button, frame_tick, bright, bird_px, pipe_px,
           pipe_passed, bird_y,
    input  pipe_run_en, physics_en, physics_clr, flap_pulse, state, score, high_score
  );

  modport slave (
    input  start_button, flap_button, frame_tick, bright, bird_px, pipe_px,
           pipe_passed, bird_y,
    output pipe_run_en, physics_en, physics_clr, flap_pulse, state, score, high_score
  );
endinterface

// File: rtl/bcd_counter4.sv
// Purpose: 4-digit BCD counter with synchronous clear and saturation at 9999.
// Latency: count updates on the clk edge that samples inc/clr; full carry in one cycle.
// Backpressure: none; inc at 9999 is silently absorbed.
// Ports: clk, reset_n (async active-low), clr (priority over inc), inc, count[15:0].
module bcd_counter4
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != BCD_MAX)) begin
      count <= bcd_inc(count);
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Purpose: Flappy Bird game sequencer: button sync, collision latch, IDLE/RUN/DYING/GAME_OVER FSM, scores.
// Latency: button edge acts 3 clk after the pin rises; enables follow the state register by 1 clk.
// Backpressure: none; pulses arriving in states that ignore them are dropped.
// Ports: clk, reset_n (async active-low), bus (slave side of game_state_ctrl_if).
module game_state_ctrl
  import flappy_pkg::*;
#(
  parameter logic [9:0] CEIL_Y       = CEIL_Y_DEF,
  parameter logic [9:0] FLOOR_Y      = FLOOR_Y_DEF,
  parameter logic [7:0] DEATH_FRAMES = DEATH_FRAMES_DEF
) (
  input logic               clk,
  input logic               reset_n,
  game_state_ctrl_if.slave  bus
);

  // Two flops for metastability, a third holds the previous synchronised level.
  logic start_s1, start_s2, start_s3;
  logic flap_s1, flap_s2, flap_s3;
  logic start_edge, flap_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
      flap_s1  <= 1'b0;
      flap_s2  <= 1'b0;
      flap_s3  <= 1'b0;
    end else begin
      start_s1 <= bus.start_button;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      flap_s1  <= bus.flap_button;
      flap_s2  <= flap_s1;
      flap_s3  <= flap_s2;
    end
  end

  assign start_edge = start_s2 & ~start_s3;
  assign flap_edge  = flap_s2 & ~flap_s3;

  // Collision latch: the frame_tick consumes the old value, while a new
  // overlap on that same cycle is kept for the following frame.
  logic hit_latch, hit_set, edge_hit, die_now;

  assign hit_set  = bus.bright & bus.bird_px & bus.pipe_px;
  assign edge_hit = (bus.bird_y <= CEIL_Y) | (bus.bird_y >= FLOOR_Y);
  assign die_now  = bus.frame_tick & (hit_latch | edge_hit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_latch <= 1'b0;
    end else if (hit_set) begin
      hit_latch <= 1'b1;
    end else if (bus.frame_tick) begin
      hit_latch <= 1'b0;
    end
  end

  state_t      state_q;
  logic [7:0]  death_cnt;
  logic [15:0] high_q;
  logic [15:0] score;
  logic        pipe_run_en_q, physics_en_q, physics_clr_q;
  logic        score_clr, score_inc;

  // Score clears on RUN entry; death on the same cycle as a pipe pass drops the pass.
  assign score_clr = (state_q == ST_IDLE) & (start_edge | flap_edge);
  assign score_inc = (state_q == ST_RUN) & bus.pipe_passed & ~die_now;

  bcd_counter4 u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (score_clr),
    .inc     (score_inc),
    .count   (score)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      death_cnt     <= '0;
      high_q        <= '0;
      pipe_run_en_q <= 1'b0;
      physics_en_q  <= 1'b0;
      physics_clr_q <= 1'b0;
    end else begin
      // Enables are derived from the state held before this edge.
      pipe_run_en_q <= (state_q == ST_RUN);
      physics_en_q  <= (state_q == ST_RUN) | (state_q == ST_DYING);
      physics_clr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_edge | flap_edge) begin
            state_q       <= ST_RUN;
            physics_clr_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (die_now) begin
            state_q   <= ST_DYING;
            death_cnt <= '0;
            if (score > high_q) high_q <= score;
          end
        end
        ST_DYING: begin
          if (bus.frame_tick) begin
            if (death_cnt == DEATH_FRAMES - 8'd1) state_q <= ST_GAME_OVER;
            death_cnt <= death_cnt + 8'd1;
          end
        end
        ST_GAME_OVER: begin
          if (start_edge) begin
            state_q       <= ST_IDLE;
            physics_clr_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pipe_run_en = pipe_run_en_q;
  assign bus.physics_en  = physics_en_q;
  assign bus.physics_clr = physics_clr_q;
  assign bus.flap_pulse  = flap_edge & (state_q == ST_RUN);
  assign bus.state       = state_q;
  assign bus.score       = score;
  assign bus.high_score  = high_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Purpose: self-checking bench for game_state_ctrl with a behavioural game model.
// Latency: model outputs are compared every negedge against the DUT.
// Backpressure: n/a.
module tb_game_state_ctrl;

  localparam int CEIL  = 35;
  localparam int FLOOR = 500;
  localparam int DEATH = 60;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  game_state_ctrl_if bus_if();

  game_state_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int n_chk = 0;
  int n_fail = 0;
  int clr_cnt = 0;
  int run_entries = 0;
  bit done = 1'b0;
  logic [1:0] prev_state = 2'd0;

  task automatic finish_run();
    if (!done) begin
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Behavioural model: integer score, plain game rules, pin history for sync latency.
  int       m_state = 0;
  int       m_score = 0;
  int       m_high = 0;
  int       m_ticks = 0;
  bit       m_hit = 0, m_pipe = 0, m_phys = 0, m_clr = 0;
  bit [2:0] sh = 3'b0, fh = 3'b0;   // [0]=newest pin sample

  always @(posedge clk or negedge reset_n) begin
    bit se, fe, die;
    if (!reset_n) begin
      m_state = 0; m_score = 0; m_high = 0; m_ticks = 0;
      m_hit = 0; m_pipe = 0; m_phys = 0; m_clr = 0;
      sh = 3'b0; fh = 3'b0;
    end else begin
      se  = sh[1] && !sh[2];
      fe  = fh[1] && !fh[2];
      die = bus_if.frame_tick &&
            (m_hit || int'(bus_if.bird_y) <= CEIL || int'(bus_if.bird_y) >= FLOOR);
      m_pipe = (m_state == 1);
      m_phys = (m_state == 1) || (m_state == 2);
      m_clr  = 0;
      case (m_state)
        0: if (se || fe) begin m_state = 1; m_score = 0; m_clr = 1; end
        1: begin
          if (die) begin
            m_state = 2; m_ticks = 0;
            if (m_score > m_high) m_high = m_score;
          end else if (bus_if.pipe_passed && m_score < 9999) begin
            m_score++;
          end
        end
        2: if (bus_if.frame_tick) begin
          m_ticks++;
          if (m_ticks == DEATH) m_state = 3;
        end
        default: if (se) begin m_state = 0; m_clr = 1; end
      endcase
      if (bus_if.bright && bus_if.bird_px && bus_if.pipe_px) m_hit = 1;
      else if (bus_if.frame_tick) m_hit = 0;
      sh = {sh[1:0], bus_if.start_button};
      fh = {fh[1:0], bus_if.flap_button};
    end
  end

  // Single compare process: every cycle, all outputs against the model.
  always @(negedge clk) begin
    logic [37:0] act, exp;
    bit m_flap;
    m_flap = fh[1] && !fh[2] && (m_state == 1);
    act = {bus_if.state, bus_if.pipe_run_en, bus_if.physics_en, bus_if.physics_clr,
           bus_if.flap_pulse, bus_if.score, bus_if.high_score};
    exp = {2'(m_state), m_pipe, m_phys, m_clr, m_flap, to_bcd(m_score), to_bcd(m_high)};
    chk("cycle_outputs", act, exp);
    if (bus_if.physics_clr) clr_cnt++;
    if (bus_if.state == 2'd1 && prev_state != 2'd1) run_entries++;
    prev_state = bus_if.state;
    if (n_fail >= 100) finish_run();
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_frame();
    bus_if.frame_tick = 1'b1;
    cyc(1);
    bus_if.frame_tick = 1'b0;
    cyc(2);
  endtask

  task automatic press_start();
    bus_if.start_button = 1'b1;
    cyc(5);
    bus_if.start_button = 1'b0;
    cyc(3);
  endtask

  task automatic press_flap();
    bus_if.flap_button = 1'b1;
    cyc(5);
    bus_if.flap_button = 1'b0;
    cyc(3);
  endtask

  task automatic pass_pipes(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.pipe_passed = 1'b1;
      cyc(1);
      bus_if.pipe_passed = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    #1_500_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    bus_if.start_button = 1'b0;
    bus_if.flap_button  = 1'b0;
    bus_if.frame_tick   = 1'b0;
    bus_if.bright       = 1'b0;
    bus_if.bird_px      = 1'b0;
    bus_if.pipe_px      = 1'b0;
    bus_if.pipe_passed  = 1'b0;
    bus_if.bird_y       = 10'd200;
    reset_n = 1'b0;
    cyc(3);
    chk("reset_state", bus_if.state, 0);
    chk("reset_score", bus_if.score, 0);
    chk("reset_pipe_en", bus_if.pipe_run_en, 0);
    reset_n = 1'b1;
    cyc(2);

    // Held start button: one RUN entry, one clear pulse.
    clr_cnt = 0;
    run_entries = 0;
    bus_if.start_button = 1'b1;
    cyc(20);
    bus_if.start_button = 1'b0;
    cyc(2);
    chk("held_start_run_entries", run_entries, 1);
    chk("held_start_clr_pulses", clr_cnt, 1);
    chk("held_start_state", bus_if.state, 1);
    chk("held_start_pipe_en", bus_if.pipe_run_en, 1);

    // Scoring and saturation.
    bus_if.pipe_passed = 1'b1;
    cyc(12);
    bus_if.pipe_passed = 1'b0;
    cyc(1);
    chk("score_12", bus_if.score, 16'h0012);
    bus_if.pipe_passed = 1'b1;
    cyc(9986);
    bus_if.pipe_passed = 1'b0;
    cyc(1);
    chk("score_9998", bus_if.score, 16'h9998);
    bus_if.pipe_passed = 1'b1;
    cyc(3);
    bus_if.pipe_passed = 1'b0;
    cyc(1);
    chk("score_saturate", bus_if.score, 16'h9999);

    // Mid-frame overlap -> DYING at the next frame_tick.
    bus_if.bright = 1'b1; bus_if.bird_px = 1'b1; bus_if.pipe_px = 1'b1;
    cyc(1);
    bus_if.bright = 1'b0; bus_if.bird_px = 1'b0; bus_if.pipe_px = 1'b0;
    cyc(5);
    chk("hit_waits_for_frame", bus_if.state, 1);
    bus_if.frame_tick = 1'b1;
    cyc(1);
    bus_if.frame_tick = 1'b0;
    chk("hit_dying", bus_if.state, 2);
    cyc(1);
    chk("dying_pipe_en", bus_if.pipe_run_en, 0);
    chk("dying_phys_en", bus_if.physics_en, 1);
    chk("dying_high", bus_if.high_score, 16'h9999);
    repeat (DEATH - 1) tick_frame();
    chk("dying_59_ticks", bus_if.state, 2);
    tick_frame();
    chk("game_over_60_ticks", bus_if.state, 3);
    press_flap();
    chk("game_over_flap_ignored", bus_if.state, 3);
    press_start();
    chk("game_over_to_idle", bus_if.state, 0);
    chk("idle_score_held", bus_if.score, 16'h9999);

    // Fresh session for high score tracking.
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(2);
    press_start();
    chk("run1_score_clear", bus_if.score, 0);
    pass_pipes(5);
    bus_if.bird_y = 10'(FLOOR);
    bus_if.frame_tick = 1'b1;
    bus_if.pipe_passed = 1'b1;
    cyc(1);
    bus_if.frame_tick = 1'b0;
    bus_if.pipe_passed = 1'b0;
    bus_if.bird_y = 10'd200;
    chk("floor_dying", bus_if.state, 2);
    chk("floor_pass_dropped", bus_if.score, 16'h0005);
    chk("run1_high", bus_if.high_score, 16'h0005);
    repeat (DEATH) tick_frame();
    press_start();
    chk("run1_idle_score", bus_if.score, 16'h0005);
    press_flap();
    chk("run2_state", bus_if.state, 1);
    chk("run2_score_clear", bus_if.score, 0);
    pass_pipes(3);
    bus_if.bird_y = 10'(CEIL);
    tick_frame();
    bus_if.bird_y = 10'd200;
    chk("ceil_dying", bus_if.state, 2);
    chk("run2_score", bus_if.score, 16'h0003);
    chk("run2_high_kept", bus_if.high_score, 16'h0005);

    // Asynchronous reset in the middle of DYING.
    repeat (3) tick_frame();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {bus_if.state, bus_if.pipe_run_en, bus_if.physics_en, bus_if.physics_clr,
         bus_if.flap_pulse, bus_if.score, bus_if.high_score}, 38'h0);
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    // Random play checked cycle by cycle against the model.
    for (int i = 0; i < 30000; i++) begin
      int r;
      r = int'($urandom_range(0, 1999));
      bus_if.frame_tick  = (i % 50 == 49);
      bus_if.bright      = 1'($urandom_range(0, 1));
      bus_if.bird_px     = (r < 3);
      bus_if.pipe_px     = 1'($urandom_range(0, 1));
      bus_if.pipe_passed = ($urandom_range(0, 15) == 0);
      bus_if.bird_y      = ($urandom_range(0, 199) == 0) ? 10'($urandom_range(0, 1023))
                                                        : 10'($urandom_range(36, 499));
      if ($urandom_range(0, 59) == 0) bus_if.start_button = ~bus_if.start_button;
      if ($urandom_range(0, 29) == 0) bus_if.flap_button = ~bus_if.flap_button;
      cyc(1);
    end

    finish_run();
  end

endmodule
